fc_layer_sched: RTL and testbench

- Sequences one shared fully-connected dot-product unit across all output neurons of an FC layer.
- For each neuron: fetches the neuron's weight row from a weight ROM, restarts the unit, waits for its finish flag, captures the accumulated result and streams it out with a valid/ready handshake.
- Sits between the layer controller (start/done) and the dot-product unit plus weight ROM. The input feature vector is wired to the unit directly by the parent.

---
 rtl/fc_pkg.sv | 27 ++
 rtl/fc_layer_sched.sv | 184 ++++++++++++++++++
 tb/tb_fc_layer_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer scheduler: FSM encoding,
// default word width and an index-width helper.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_EMIT   = 3'd5,
        ST_FIN    = 3'd6
    } fc_state_t;

    localparam int FC_DATA_WIDTH = 16;

    // Bits needed to represent the values 0..n-1, never fewer than one.
    function automatic int fc_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fc_layer_sched.sv
// Time-shares one dot-product unit across the output neurons of an FC layer:
// fetch weight row, restart unit, wait for finish, emit result with valid/ready.
module fc_layer_sched
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int NUM_IN     = 100,
    parameter int NUM_OUT    = 10,
    parameter int IDX_W      = fc_clog2(NUM_OUT),
    parameter int PE_LAT     = 1,
    parameter int WDOG       = 120
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [IDX_W:0]               cfg_num_out,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         w_rd_en,
    output logic [IDX_W-1:0]             w_addr,
    input  logic [NUM_IN*DATA_WIDTH-1:0] w_rdata,
    output logic                         unit_reset,
    output logic [NUM_IN*DATA_WIDTH-1:0] unit_filter,
    input  logic                         unit_over,
    input  logic [DATA_WIDTH-1:0]        unit_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]             out_idx
);

    localparam int WD_W = fc_clog2(WDOG);
    localparam int ST_W = fc_clog2(PE_LAT);

    localparam logic [WD_W-1:0]  WDOG_LAST   = WD_W'(WDOG - 1);
    localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'((PE_LAT > 0) ? PE_LAT - 1 : 0);
    localparam logic [IDX_W:0]   NUM_OUT_W   = (IDX_W + 1)'(NUM_OUT);
    localparam logic [IDX_W:0]   IDX_ONE_W   = (IDX_W + 1)'(1);

    fc_state_t                   state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [IDX_W:0]              n_tot_q, n_tot_d;
    logic                        err_q, err_d;
    logic [WD_W-1:0]             wdog_q, wdog_d;
    logic [ST_W-1:0]             settle_q, settle_d;
    logic [NUM_IN*DATA_WIDTH-1:0] filter_q, filter_d;
    logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic [IDX_W-1:0]            out_idx_q, out_idx_d;
    logic                        out_valid_q, out_valid_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            n_tot_q     <= '0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
            settle_q    <= '0;
            filter_q    <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_tot_q     <= n_tot_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
            settle_q    <= settle_d;
            filter_q    <= filter_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_tot_d     = n_tot_q;
        err_d       = err_q;
        wdog_d      = wdog_q;
        settle_d    = settle_q;
        filter_d    = filter_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        busy        = 1'b0;
        done        = 1'b0;
        w_rd_en     = 1'b0;
        unit_reset  = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_tot_d = (cfg_num_out > NUM_OUT_W) ? NUM_OUT_W : cfg_num_out;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = (n_tot_d == '0) ? ST_FIN : ST_FETCH;
                end
            end

            ST_FETCH: begin
                busy    = 1'b1;
                w_rd_en = 1'b1;
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                busy     = 1'b1;
                filter_d = w_rdata;
                wdog_d   = '0;
                state_d  = ST_RUN;
            end

            ST_RUN: begin
                busy       = 1'b1;
                unit_reset = 1'b0;
                // A finish on the last watchdog cycle still counts as a finish.
                if (unit_over) begin
                    if (PE_LAT == 0) begin
                        out_data_d  = unit_result;
                        out_idx_d   = idx_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_EMIT;
                    end else begin
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end

            ST_SETTLE: begin
                busy       = 1'b1;
                unit_reset = 1'b0;
                if (settle_q == SETTLE_LAST) begin
                    out_data_d  = unit_result;
                    out_idx_d   = idx_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end else begin
                    settle_d = settle_q + ST_W'(1);
                end
            end

            ST_EMIT: begin
                busy = 1'b1;
                // out_valid_q is high for the whole of EMIT, so ready alone completes it.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (({1'b0, idx_q} + IDX_ONE_W) == n_tot_q) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign err         = err_q;
    assign w_addr      = idx_q;
    assign unit_filter = filter_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_idx     = out_idx_q;

endmodule

// File: tb/tb_fc_layer_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for fc_layer_sched: behavioural weight ROM and dot-product unit
// around the scheduler; expected words are queued per pass and popped by a monitor.
module tb_fc_layer_sched;

    localparam int DW = 16;
    localparam int NI = 4;
    localparam int NO = 10;
    localparam int IW = 4;
    localparam int PL = 1;
    localparam int WD = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [IW:0]       cfg_num_out;
    logic              busy;
    logic              done;
    logic              err;
    logic              w_rd_en;
    logic [IW-1:0]     w_addr;
    logic [NI*DW-1:0]  w_rdata;
    logic              unit_reset;
    logic [NI*DW-1:0]  unit_filter;
    logic              unit_over;
    logic [DW-1:0]     unit_result;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_idx;

    logic [DW-1:0]     rom [NO][NI];
    int unsigned       t_tab [NO];
    logic              hang;
    int unsigned       cur_t = 1;
    int unsigned       ucnt = 0;
    logic              rdy_mode;
    logic              rdy_force;

    logic [DW-1:0]     exp_data_q [$];
    logic [IW-1:0]     exp_idx_q [$];
    logic [IW-1:0]     exp_addr_q [$];

    int                n_chk = 0;
    int                n_fail = 0;
    int                done_cnt = 0;
    int                pass_dc0 = 0;
    int                dc_rst = 0;
    int                k = 0;

    logic              mon_pv = 1'b0;
    logic              mon_pr = 1'b0;
    logic [DW-1:0]     mon_pd = '0;
    logic [IW-1:0]     mon_pi = '0;

    fc_layer_sched #(
        .DATA_WIDTH (DW),
        .NUM_IN     (NI),
        .NUM_OUT    (NO),
        .IDX_W      (IW),
        .PE_LAT     (PL),
        .WDOG       (WD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_num_out (cfg_num_out),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .w_rd_en     (w_rd_en),
        .w_addr      (w_addr),
        .w_rdata     (w_rdata),
        .unit_reset  (unit_reset),
        .unit_filter (unit_filter),
        .unit_over   (unit_over),
        .unit_result (unit_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx)
    );

    always #5 clk = ~clk;

    // Fixed input feature vector seen by the unit: 1, 3, 5, 7.
    function automatic logic [DW-1:0] feat(input int i);
        return DW'(2 * i + 1);
    endfunction

    function automatic logic [DW-1:0] ref_dot(input int r);
        logic [DW-1:0] acc;
        acc = '0;
        for (int i = 0; i < NI; i++) acc = acc + DW'(rom[r][i] * feat(i));
        return acc;
    endfunction

    function automatic logic [DW-1:0] unit_dot(input logic [NI*DW-1:0] f);
        logic [DW-1:0] acc;
        acc = '0;
        for (int i = 0; i < NI; i++) acc = acc + DW'(f[i*DW +: DW] * feat(i));
        return acc;
    endfunction

    // Weight ROM: row appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (w_rd_en && int'(w_addr) < NO) begin
            for (int i = 0; i < NI; i++) w_rdata[i*DW +: DW] <= rom[w_addr][i];
            cur_t <= t_tab[w_addr];
        end
        if (unit_reset) ucnt <= 0;
        else            ucnt <= ucnt + 1;
    end

    // Unit finishes on RUN cycle cur_t; result is garbage until PL cycles later.
    assign unit_over   = !unit_reset && !hang && (ucnt + 1 >= cur_t);
    assign unit_result = (!unit_reset && (ucnt + 1 >= cur_t + PL)) ? unit_dot(unit_filter) : 16'hDEAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_busy"},        busy, 0);
        chk({tag, "_done"},        done, 0);
        chk({tag, "_err"},         err, 0);
        chk({tag, "_w_rd_en"},     w_rd_en, 0);
        chk({tag, "_w_addr"},      w_addr, 0);
        chk({tag, "_unit_filter"}, unit_filter, 0);
        chk({tag, "_out_valid"},   out_valid, 0);
        chk({tag, "_out_data"},    out_data, 0);
        chk({tag, "_out_idx"},     out_idx, 0);
        chk({tag, "_unit_reset"},  unit_reset, 1);
    endtask

    task automatic randomize_env();
        for (int r = 0; r < NO; r++) begin
            for (int i = 0; i < NI; i++) rom[r][i] = DW'($urandom);
            t_tab[r] = $urandom_range(1, 8);
        end
    endtask

    task automatic issue_pass(input int n, input bit hangs);
        int nt;
        nt = (n > NO) ? NO : n;
        for (int i = 0; i < nt; i++) begin
            if (!hangs || i == 0) exp_addr_q.push_back(IW'(i));
            if (!hangs) begin
                exp_data_q.push_back(ref_dot(i));
                exp_idx_q.push_back(IW'(i));
            end
        end
        pass_dc0    = done_cnt;
        cfg_num_out = (IW + 1)'(n);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        cfg_num_out = (IW + 1)'($urandom);
        chk("err_cleared_by_start", err, 0);
        if (nt == 0) chk("done_after_start", done, 1);
        else         chk("busy_after_start", busy, 1);
    endtask

    task automatic finish_pass(input bit exp_err);
        int c;
        c = 0;
        while (done_cnt == pass_dc0 && c < 4000) begin
            tick();
            c++;
        end
        if (done_cnt == pass_dc0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", c);
        end
        tick();
        tick();
        chk("done_pulses",     done_cnt - pass_dc0, 1);
        chk("busy_after_done", busy, 0);
        chk("err_after_done",  err, exp_err);
        chk("outputs_missing", exp_data_q.size(), 0);
        chk("fetches_missing", exp_addr_q.size(), 0);
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        cfg_num_out = '0;
        hang        = 1'b0;
        rdy_mode    = 1'b0;
        rdy_force   = 1'b1;
        out_ready   = 1'b1;
        randomize_env();

        fork
            begin : ready_drv
                forever begin
                    @(posedge clk);
                    #1;
                    out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
                end
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (done) done_cnt++;
                    if (reset) begin
                        if (mon_pv && !mon_pr) begin
                            chk("hold_valid", out_valid, 1);
                            chk("hold_data",  out_data, mon_pd);
                            chk("hold_idx",   out_idx, mon_pi);
                        end
                        if (w_rd_en) begin
                            chk("no_fetch_while_valid", out_valid, 0);
                            if (exp_addr_q.size() == 0) begin
                                n_chk++;
                                n_fail++;
                                $display("FAIL unexpected_fetch: w_addr=%0d, expected no fetch", w_addr);
                            end else begin
                                chk("w_addr", w_addr, exp_addr_q.pop_front());
                            end
                        end
                        if (out_valid && out_ready) begin
                            if (exp_data_q.size() == 0) begin
                                n_chk++;
                                n_fail++;
                                $display("FAIL unexpected_output: data=%0h idx=%0d, expected none", out_data, out_idx);
                            end else begin
                                chk("out_data", out_data, exp_data_q.pop_front());
                                chk("out_idx",  out_idx,  exp_idx_q.pop_front());
                            end
                        end
                        mon_pv = out_valid;
                        mon_pr = out_ready;
                        mon_pd = out_data;
                        mon_pi = out_idx;
                    end else begin
                        mon_pv = 1'b0;
                    end
                end
            end
            begin : guard
                #1000000;
                $display("FAIL global_timeout: simulation did not finish in time");
                $fatal(1, "time limit reached");
            end
        join_none

        repeat (3) tick();
        chk_rst_outputs("reset");
        reset = 1'b1;
        tick();

        // Normal pass: three neurons with results 0100, 0200, 0300.
        for (int r = 0; r < 3; r++) begin
            rom[r][0] = DW'(16'h0100 * (r + 1));
            for (int i = 1; i < NI; i++) rom[r][i] = '0;
            t_tab[r] = 6;
        end
        issue_pass(3, 1'b0);
        finish_pass(1'b0);

        // Backpressure on neuron 1.
        randomize_env();
        issue_pass(4, 1'b0);
        k = 0;
        while (!(w_rd_en && w_addr == IW'(1)) && k < 500) begin
            tick();
            k++;
        end
        chk("bp_fetch1_seen", w_rd_en && w_addr == IW'(1), 1);
        rdy_force = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_valid_held", out_valid, 1);
            chk("bp_no_fetch",   w_rd_en, 0);
            chk("bp_idx",        out_idx, 1);
        end
        rdy_force = 1'b1;
        finish_pass(1'b0);

        // Empty pass, then a request beyond NUM_OUT with random backpressure.
        issue_pass(0, 1'b0);
        finish_pass(1'b0);
        rdy_mode = 1'b1;
        randomize_env();
        issue_pass(15, 1'b0);
        finish_pass(1'b0);
        rdy_mode = 1'b0;

        // Watchdog abort with the unit never finishing.
        hang = 1'b1;
        issue_pass(2, 1'b1);
        k = 0;
        while (!done && k < 200) begin
            tick();
            k++;
        end
        chk("wdog_done_latency", k, 2 + WD);
        chk("wdog_err",          err, 1);
        chk("wdog_unit_reset",   unit_reset, 1);
        finish_pass(1'b1);
        hang = 1'b0;
        issue_pass(2, 1'b0);
        finish_pass(1'b0);

        // Starts while busy, including one coinciding with done.
        randomize_env();
        issue_pass(4, 1'b0);
        repeat (5) tick();
        cfg_num_out = (IW + 1)'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < 500) begin
            tick();
            k++;
        end
        chk("busy_start_done_seen", done, 1);
        cfg_num_out = (IW + 1)'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_pass(1'b0);

        // Reset during RUN of neuron 1, then a fresh pass.
        randomize_env();
        t_tab[1] = 7;
        issue_pass(3, 1'b0);
        k = 0;
        while (!(w_rd_en && w_addr == IW'(1)) && k < 500) begin
            tick();
            k++;
        end
        tick();
        tick();
        chk("pre_reset_in_run", unit_reset, 0);
        dc_rst = done_cnt;
        reset = 1'b0;
        tick();
        chk_rst_outputs("midrun");
        tick();
        reset = 1'b1;
        exp_data_q.delete();
        exp_idx_q.delete();
        exp_addr_q.delete();
        tick();
        chk("no_done_on_reset", done_cnt - dc_rst, 0);
        randomize_env();
        issue_pass(5, 1'b0);
        finish_pass(1'b0);

        // Random passes with random backpressure.
        rdy_mode = 1'b1;
        for (int p = 0; p < 4; p++) begin
            randomize_env();
            issue_pass($urandom_range(1, NO), 1'b0);
            finish_pass(1'b0);
        end
        rdy_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
